gb_ps2_joypad: RTL and testbench
================================

// Module: gb_ps2_joypad
// PURPOSE
//  Sink end of the ps2_data Avalon-ST stream (8-bit scancodes from the PS/2 core, sys_clk domain).
//  Decodes PS/2 set-2 make/break/extended sequences into the 8-button DMG joypad state.
//  The joypad state feeds the P1/JOYP register and the joypad interrupt.
//  Absorbs keyboard control bytes and drops stalled partial sequences.
// PARAMETERS
//  TIMEOUT_CYCLES  2_500_000  max sys_clk cycles between bytes of one sequence (50 ms @ 50 MHz); must be >=2
// PORTS
//  sys_clk          in   1  clock; everything on posedge
//  hard_reset_n     in   1  synchronous reset, active-low
//  ps2_data_data    in   8  scancode byte
//  ps2_data_valid   in   1  byte present
//  ps2_data_ready   out  1  sink can accept; byte taken when valid&&ready
//  joypad_clear     in   1  sync release of all buttons
//  joypad           out  8  1=pressed: [0]Right [1]Left [2]Up [3]Down [4]A [5]B [6]Select [7]Start
//  key_event        out  1  1-cycle pulse when joypad changed
//  seq_abort        out  1  1-cycle pulse when a partial sequence is dropped
// BEHAVIOUR
//  Reset: state=IDLE, joypad=0, key_event=0, seq_abort=0, timer=0, ps2_data_ready=0 while hard_reset_n=0.
//  ready = (state!=APPLY); ready is combinational from state only and never depends on valid.
//  States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), APPLY.
//  Transitions on an accepted byte b:
//   IDLE:    E0->EXT; F0->BRK; AA->IDLE and joypad<=0 (BAT: keyboard reset, no key_event);
//            FA/FE/EE/E1/00/FF->IDLE (ignored); else latch {ext=0,brk=0,b}->APPLY.
//   EXT:     E0->EXT; F0->EXT_BRK; else latch {1,0,b}->APPLY.
//   BRK:     F0->BRK; E0->EXT with seq_abort pulse; else latch {0,1,b}->APPLY.
//   EXT_BRK: F0->EXT_BRK; E0->EXT with seq_abort pulse; else latch {1,1,b}->APPLY.
//   APPLY:   lasts exactly 1 cycle, no byte is accepted, then ->IDLE.
//  Key map (all else, incl. non-E0 74/6B/75/72 and E0 5A, is unmapped):
//   E0 74=Right, E0 6B=Left, E0 75=Up, E0 72=Down; 22(X)=A; 1A(Z)=B; 59(RShift)=Select; 5A(Enter)=Start.
//  APPLY: mapped make sets the bit; mapped break clears it. Unmapped code: no change.
//   joypad and key_event registered at end of APPLY.
//   key_event=1 only if joypad value actually changes, so typematic repeats do not pulse.
//  Latency: byte accepted at cycle T -> APPLY at T+1 -> new joypad and key_event visible at T+2.
//  Timeout: timer clears on every accepted byte and counts only in EXT/BRK/EXT_BRK.
//   When timer reaches TIMEOUT_CYCLES-1 with no byte: ->IDLE, seq_abort pulse, joypad unchanged.
//   A byte accepted in that same cycle wins and is processed normally, with no abort.
//  joypad_clear: joypad<=0 next cycle, FSM unaffected.
//   If it coincides with APPLY, clear wins; key_event=1 iff the pre-clear joypad was nonzero.
//  Reset mid-sequence: partial sequence discarded, all outputs return to reset values next cycle.
// TESTING
//  1 Bytes 22 then F0 22, valid held high -> joypad=0x10 at T+2, then 0x00; 2 key_event pulses; ready low only in APPLY cycles.
//  2 E0 74, E0 75, E0 F0 74 -> joypad 0x01, 0x05, 0x04; non-E0 74 -> no change, no key_event.
//  3 Bytes 5A,5A,5A (typematic) -> joypad[7]=1 after first; exactly 1 key_event.
//  4 E0, then idle TIMEOUT_CYCLES -> seq_abort pulse, state IDLE; then byte 74 alone -> no change.
//  5 Start+A held (0x90), then AA -> joypad=0x00 with no key_event; then FA, FE ignored.
//  6 Assert joypad_clear in the APPLY cycle of 1A make -> joypad=0x00; hard_reset_n low after F0 -> next 22 is a make.

Source files
------------

// File: rtl/gb_ps2_joypad.sv
// PS/2 set-2 scancode sink that turns make/break/extended sequences into the DMG joypad state.
// state   | meaning
// IDLE    | waiting for the first byte of a sequence
// EXT     | E0 prefix seen
// BRK     | F0 prefix seen
// EXT_BRK | E0 F0 prefix seen
// APPLY   | one cycle: apply latched code to joypad, sink not ready
module gb_ps2_joypad #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       sys_clk,
    input  logic       hard_reset_n,
    input  logic [7:0] ps2_data_data,
    input  logic       ps2_data_valid,
    output logic       ps2_data_ready,
    input  logic       joypad_clear,
    output logic [7:0] joypad,
    output logic       key_event,
    output logic       seq_abort
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_APPLY   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          lat_ext_q, lat_ext_d;
    logic          lat_brk_q, lat_brk_d;
    logic [7:0]    lat_code_q, lat_code_d;
    logic [7:0]    joypad_q, joypad_d;
    logic          key_event_q, key_event_d;
    logic          seq_abort_q, seq_abort_d;

    logic          accept;
    logic          in_seq;
    logic [7:0]    key_mask;
    logic [7:0]    applied;

    assign ps2_data_ready = hard_reset_n && (state_q != S_APPLY);
    assign accept         = ps2_data_valid && ps2_data_ready;
    assign in_seq         = (state_q == S_EXT) || (state_q == S_BRK) || (state_q == S_EXT_BRK);

    assign joypad    = joypad_q;
    assign key_event = key_event_q;
    assign seq_abort = seq_abort_q;

    // Extended arrow keys only; the bare keypad codes 74/6B/75/72 and E0 5A stay unmapped.
    always_comb begin
        key_mask = 8'h00;
        if (lat_ext_q) begin
            case (lat_code_q)
                8'h74:   key_mask = 8'h01;
                8'h6B:   key_mask = 8'h02;
                8'h75:   key_mask = 8'h04;
                8'h72:   key_mask = 8'h08;
                default: key_mask = 8'h00;
            endcase
        end else begin
            case (lat_code_q)
                8'h22:   key_mask = 8'h10;
                8'h1A:   key_mask = 8'h20;
                8'h59:   key_mask = 8'h40;
                8'h5A:   key_mask = 8'h80;
                default: key_mask = 8'h00;
            endcase
        end
    end

    assign applied = lat_brk_q ? (joypad_q & ~key_mask) : (joypad_q | key_mask);

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        lat_ext_d   = lat_ext_q;
        lat_brk_d   = lat_brk_q;
        lat_code_d  = lat_code_q;
        joypad_d    = joypad_q;
        key_event_d = 1'b0;
        seq_abort_d = 1'b0;

        if (in_seq && !accept) begin
            if (timer_q == TIMER_LAST) begin
                state_d     = S_IDLE;
                seq_abort_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (ps2_data_data)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hAA: joypad_d = 8'h00;
                        8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF: state_d = S_IDLE;
                        default: begin
                            lat_ext_d  = 1'b0;
                            lat_brk_d  = 1'b0;
                            lat_code_d = ps2_data_data;
                            state_d    = S_APPLY;
                        end
                    endcase
                end
            end
            S_EXT: begin
                if (accept) begin
                    case (ps2_data_data)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_EXT_BRK;
                        default: begin
                            lat_ext_d  = 1'b1;
                            lat_brk_d  = 1'b0;
                            lat_code_d = ps2_data_data;
                            state_d    = S_APPLY;
                        end
                    endcase
                end
            end
            S_BRK, S_EXT_BRK: begin
                if (accept) begin
                    case (ps2_data_data)
                        8'hF0: state_d = state_q;
                        8'hE0: begin
                            state_d     = S_EXT;
                            seq_abort_d = 1'b1;
                        end
                        default: begin
                            lat_ext_d  = (state_q == S_EXT_BRK);
                            lat_brk_d  = 1'b1;
                            lat_code_d = ps2_data_data;
                            state_d    = S_APPLY;
                        end
                    endcase
                end
            end
            S_APPLY: begin
                state_d  = S_IDLE;
                joypad_d = applied;
            end
            default: state_d = S_IDLE;
        endcase

        // Clear overrides the APPLY result; the event then reflects the pre-clear value.
        if (joypad_clear) begin
            joypad_d = 8'h00;
        end
        if (state_q == S_APPLY) begin
            key_event_d = (joypad_d != joypad_q);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!hard_reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            lat_ext_q   <= 1'b0;
            lat_brk_q   <= 1'b0;
            lat_code_q  <= 8'h00;
            joypad_q    <= 8'h00;
            key_event_q <= 1'b0;
            seq_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lat_ext_q   <= lat_ext_d;
            lat_brk_q   <= lat_brk_d;
            lat_code_q  <= lat_code_d;
            joypad_q    <= joypad_d;
            key_event_q <= key_event_d;
            seq_abort_q <= seq_abort_d;
        end
    end

endmodule

// File: tb/tb_gb_ps2_joypad.sv
// Directed bench for gb_ps2_joypad: per-cycle vector table plus timeout and reset sequences.
module tb_gb_ps2_joypad;

    localparam int TO = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       clr;
    logic [7:0] joy;
    logic       ev;
    logic       ab;

    int tests;
    int fails;

    gb_ps2_joypad #(.TIMEOUT_CYCLES(TO)) dut (
        .sys_clk        (clk),
        .hard_reset_n   (rst_n),
        .ps2_data_data  (data),
        .ps2_data_valid (valid),
        .ps2_data_ready (ready),
        .joypad_clear   (clr),
        .joypad         (joy),
        .key_event      (ev),
        .seq_abort      (ab)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs driven for one posedge, outputs expected at the following negedge.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       r;
        logic [7:0] j;
        logic       e;
        logic       a;
    } row_t;

    row_t rows[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic c,
                                input logic r, input logic [7:0] j, input logic e,
                                input logic a);
        row_t t;
        t.v = v; t.d = d; t.c = c; t.r = r; t.j = j; t.e = e; t.a = a;
        rows.push_back(t);
    endfunction

    task automatic check(input string name, input logic r, input logic [7:0] j,
                         input logic e, input logic a);
        tests++;
        if (ready !== r || joy !== j || ev !== e || ab !== a) begin
            fails++;
            $display("FAIL %s: got ready=%0b joypad=%02h key_event=%0b seq_abort=%0b, want ready=%0b joypad=%02h key_event=%0b seq_abort=%0b",
                     name, ready, joy, ev, ab, r, j, e, a);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic c);
        valid = v;
        data  = d;
        clr   = c;
    endtask

    initial begin
        int k;
        int abort_at;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        // valid held high across the APPLY cycle: 22 make then F0 22 break
        add(1, 8'h22, 0, 0, 8'h00, 0, 0);
        add(1, 8'hF0, 0, 1, 8'h10, 1, 0);
        add(1, 8'hF0, 0, 1, 8'h10, 0, 0);
        add(1, 8'h22, 0, 0, 8'h10, 0, 0);
        add(0, 8'h00, 0, 1, 8'h00, 1, 0);
        // extended arrows, then non-extended 74 is unmapped
        add(1, 8'hE0, 0, 1, 8'h00, 0, 0);
        add(1, 8'h74, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 8'h01, 1, 0);
        add(1, 8'hE0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h75, 0, 0, 8'h01, 0, 0);
        add(0, 8'h00, 0, 1, 8'h05, 1, 0);
        add(1, 8'hE0, 0, 1, 8'h05, 0, 0);
        add(1, 8'hF0, 0, 1, 8'h05, 0, 0);
        add(1, 8'h74, 0, 0, 8'h05, 0, 0);
        add(0, 8'h00, 0, 1, 8'h04, 1, 0);
        add(1, 8'h74, 0, 0, 8'h04, 0, 0);
        add(0, 8'h00, 0, 1, 8'h04, 0, 0);
        // typematic Enter: one event only
        add(1, 8'h5A, 0, 0, 8'h04, 0, 0);
        add(1, 8'h5A, 0, 1, 8'h84, 1, 0);
        add(1, 8'h5A, 0, 0, 8'h84, 0, 0);
        add(1, 8'h5A, 0, 1, 8'h84, 0, 0);
        add(1, 8'h5A, 0, 0, 8'h84, 0, 0);
        add(0, 8'h00, 0, 1, 8'h84, 0, 0);
        // release Up, press A -> 0x90, then BAT and ignored control bytes
        add(1, 8'hE0, 0, 1, 8'h84, 0, 0);
        add(1, 8'hF0, 0, 1, 8'h84, 0, 0);
        add(1, 8'h75, 0, 0, 8'h84, 0, 0);
        add(0, 8'h00, 0, 1, 8'h80, 1, 0);
        add(1, 8'h22, 0, 0, 8'h80, 0, 0);
        add(0, 8'h00, 0, 1, 8'h90, 1, 0);
        add(1, 8'hAA, 0, 1, 8'h00, 0, 0);
        add(1, 8'hFA, 0, 1, 8'h00, 0, 0);
        add(1, 8'hFE, 0, 1, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 8'h00, 0, 0);
        // F0 then E0 abandons the break prefix
        add(1, 8'hF0, 0, 1, 8'h00, 0, 0);
        add(1, 8'hE0, 0, 1, 8'h00, 0, 1);
        add(1, 8'h74, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 8'h01, 1, 0);
        add(1, 8'hE0, 0, 1, 8'h01, 0, 0);
        add(1, 8'hF0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h74, 0, 0, 8'h01, 0, 0);
        add(0, 8'h00, 0, 1, 8'h00, 1, 0);
        // E0 5A is unmapped
        add(1, 8'hE0, 0, 1, 8'h00, 0, 0);
        add(1, 8'h5A, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 8'h00, 0, 0);
        // joypad_clear during APPLY of a Z make
        add(1, 8'h22, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 8'h10, 1, 0);
        add(1, 8'h1A, 0, 0, 8'h10, 0, 0);
        add(0, 8'h00, 1, 1, 8'h00, 1, 0);
        add(1, 8'h1A, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 1, 8'h00, 0, 0);

        // reset state
        repeat (3) @(negedge clk);
        check("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", 1'b1, 8'h00, 1'b0, 1'b0);

        foreach (rows[i]) begin
            drive(rows[i].v, rows[i].d, rows[i].c);
            @(negedge clk);
            check($sformatf("row%0d", i), rows[i].r, rows[i].j, rows[i].e, rows[i].a);
        end
        drive(1'b0, 8'h00, 1'b0);

        // timeout after a lone E0
        drive(1'b1, 8'hE0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        abort_at = -1;
        for (k = 1; k <= 3 * TO; k++) begin
            @(negedge clk);
            if (ab === 1'b1) begin
                abort_at = k;
                break;
            end
        end
        tests++;
        if (abort_at != TO) begin
            fails++;
            $display("FAIL timeout_cycle: abort seen at %0d, want %0d", abort_at, TO);
        end
        @(negedge clk);
        check("timeout_pulse_end", 1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h74, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("bare74_after_timeout", 1'b1, 8'h00, 1'b0, 1'b0);

        // byte arriving in the timeout cycle wins
        drive(1'b1, 8'hE0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        abort_at = 0;
        for (k = 1; k < TO; k++) begin
            @(negedge clk);
            if (ab === 1'b1) abort_at++;
        end
        drive(1'b1, 8'h74, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        check("late_byte_apply", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("late_byte_wins", 1'b1, 8'h01, 1'b1, 1'b0);
        tests++;
        if (abort_at != 0) begin
            fails++;
            $display("FAIL early_abort: %0d abort pulses before timeout, want 0", abort_at);
        end

        // reset after F0 discards the break prefix
        drive(1'b1, 8'hF0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_seq_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 8'h22, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("make_after_reset", 1'b1, 8'h10, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
